// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: loader mnemonic codes, opcodes, functs, FSM states.
// Also imported by the main-control decoder for the opcode constants.
package mips_isa_pkg;

    // Loader mnemonic codes
    localparam logic [5:0] MN_ADD   = 6'd0;
    localparam logic [5:0] MN_ADDU  = 6'd1;
    localparam logic [5:0] MN_SUB   = 6'd2;
    localparam logic [5:0] MN_AND   = 6'd3;
    localparam logic [5:0] MN_OR    = 6'd4;
    localparam logic [5:0] MN_XOR   = 6'd5;
    localparam logic [5:0] MN_NOR   = 6'd6;
    localparam logic [5:0] MN_SLT   = 6'd7;
    localparam logic [5:0] MN_SLTU  = 6'd8;
    localparam logic [5:0] MN_SLL   = 6'd9;
    localparam logic [5:0] MN_SRL   = 6'd10;
    localparam logic [5:0] MN_JR    = 6'd11;
    localparam logic [5:0] MN_ADDI  = 6'd16;
    localparam logic [5:0] MN_ADDIU = 6'd17;
    localparam logic [5:0] MN_ANDI  = 6'd18;
    localparam logic [5:0] MN_ORI   = 6'd19;
    localparam logic [5:0] MN_XORI  = 6'd20;
    localparam logic [5:0] MN_SLTI  = 6'd21;
    localparam logic [5:0] MN_SLTIU = 6'd22;
    localparam logic [5:0] MN_LUI   = 6'd23;
    localparam logic [5:0] MN_LW    = 6'd24;
    localparam logic [5:0] MN_LB    = 6'd25;
    localparam logic [5:0] MN_LH    = 6'd26;
    localparam logic [5:0] MN_SW    = 6'd27;
    localparam logic [5:0] MN_SB    = 6'd28;
    localparam logic [5:0] MN_SH    = 6'd29;
    localparam logic [5:0] MN_BEQ   = 6'd32;
    localparam logic [5:0] MN_BNE   = 6'd33;
    localparam logic [5:0] MN_BLEZ  = 6'd34;
    localparam logic [5:0] MN_BGTZ  = 6'd35;
    localparam logic [5:0] MN_BLTZ  = 6'd36;
    localparam logic [5:0] MN_BGEZ  = 6'd37;
    localparam logic [5:0] MN_J     = 6'd40;
    localparam logic [5:0] MN_JAL   = 6'd41;
    localparam logic [5:0] MN_MADD  = 6'd48;
    localparam logic [5:0] MN_MSUB  = 6'd49;
    localparam logic [5:0] MN_MUL   = 6'd50;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BLEZ     = 6'h06;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;

    // R-type functs
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // Special2 functs
    localparam logic [5:0] F2_MADD = 6'h00;
    localparam logic [5:0] F2_MUL  = 6'h02;
    localparam logic [5:0] F2_MSUB = 6'h04;

    // REGIMM rt selectors
    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FULL,
        ST_ERROR
    } enc_state_e;

    function automatic logic [31:0] enc_r(
        input logic [5:0] op,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] sh,
        input logic [5:0] fn
    );
        return {op, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(
        input logic [5:0]  op,
        input logic [25:0] tgt
    );
        return {op, tgt};
    endfunction

endpackage

// File: rtl/instr_word_builder.sv
// Combinational mnemonic + fields -> 32-bit MIPS word, with illegal flag.
// Codes 48-50 (special2) are legal only when ENC_SPECIAL2_EN is defined.
module instr_word_builder
    import mips_isa_pkg::*;
(
    input  logic [5:0]  mn_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // Select format per mnemonic, zeroing fields the format does not use
    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        unique case (mn_i)
            MN_ADD:   word_o = enc_r(OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_ADD);
            MN_ADDU:  word_o = enc_r(OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_ADDU);
            MN_SUB:   word_o = enc_r(OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_SUB);
            MN_AND:   word_o = enc_r(OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_AND);
            MN_OR:    word_o = enc_r(OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_OR);
            MN_XOR:   word_o = enc_r(OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_XOR);
            MN_NOR:   word_o = enc_r(OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_NOR);
            MN_SLT:   word_o = enc_r(OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_SLT);
            MN_SLTU:  word_o = enc_r(OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_SLTU);
            MN_SLL:   word_o = enc_r(OP_RTYPE, 5'd0, rt_i, rd_i, shamt_i, F_SLL);
            MN_SRL:   word_o = enc_r(OP_RTYPE, 5'd0, rt_i, rd_i, shamt_i, F_SRL);
            MN_JR:    word_o = enc_r(OP_RTYPE, rs_i, 5'd0, 5'd0, 5'd0, F_JR);
            MN_ADDI:  word_o = enc_i(OP_ADDI, rs_i, rt_i, imm_i);
            MN_ADDIU: word_o = enc_i(OP_ADDIU, rs_i, rt_i, imm_i);
            MN_ANDI:  word_o = enc_i(OP_ANDI, rs_i, rt_i, imm_i);
            MN_ORI:   word_o = enc_i(OP_ORI, rs_i, rt_i, imm_i);
            MN_XORI:  word_o = enc_i(OP_XORI, rs_i, rt_i, imm_i);
            MN_SLTI:  word_o = enc_i(OP_SLTI, rs_i, rt_i, imm_i);
            MN_SLTIU: word_o = enc_i(OP_SLTIU, rs_i, rt_i, imm_i);
            MN_LUI:   word_o = enc_i(OP_LUI, 5'd0, rt_i, imm_i);
            MN_LW:    word_o = enc_i(OP_LW, rs_i, rt_i, imm_i);
            MN_LB:    word_o = enc_i(OP_LB, rs_i, rt_i, imm_i);
            MN_LH:    word_o = enc_i(OP_LH, rs_i, rt_i, imm_i);
            MN_SW:    word_o = enc_i(OP_SW, rs_i, rt_i, imm_i);
            MN_SB:    word_o = enc_i(OP_SB, rs_i, rt_i, imm_i);
            MN_SH:    word_o = enc_i(OP_SH, rs_i, rt_i, imm_i);
            MN_BEQ:   word_o = enc_i(OP_BEQ, rs_i, rt_i, imm_i);
            MN_BNE:   word_o = enc_i(OP_BNE, rs_i, rt_i, imm_i);
            MN_BLEZ:  word_o = enc_i(OP_BLEZ, rs_i, 5'd0, imm_i);
            MN_BGTZ:  word_o = enc_i(OP_BGTZ, rs_i, 5'd0, imm_i);
            MN_BLTZ:  word_o = enc_i(OP_REGIMM, rs_i, RT_BLTZ, imm_i);
            MN_BGEZ:  word_o = enc_i(OP_REGIMM, rs_i, RT_BGEZ, imm_i);
            MN_J:     word_o = enc_j(OP_J, target_i);
            MN_JAL:   word_o = enc_j(OP_JAL, target_i);
`ifdef ENC_SPECIAL2_EN
            MN_MADD:  word_o = enc_r(OP_SPECIAL2, rs_i, rt_i, 5'd0, 5'd0, F2_MADD);
            MN_MSUB:  word_o = enc_r(OP_SPECIAL2, rs_i, rt_i, 5'd0, 5'd0, F2_MSUB);
            MN_MUL:   word_o = enc_r(OP_SPECIAL2, rs_i, rt_i, rd_i, 5'd0, F2_MUL);
`endif
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: symbolic instruction stream -> sequential instruction-memory writes.
// Define ENC_SPECIAL2_EN to accept MADD/MSUB/MUL (codes 48-50).
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5:0]               in_mn,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_shamt,
    input  logic [15:0]              in_imm,
    input  logic [25:0]              in_target,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     err
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    enc_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          mem_we_q;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic [31:0]   word;
    logic          illegal;
    logic          accept;
    logic          wr_ok;
    logic          bad_mn;
    logic          last;

    instr_word_builder u_builder (
        .mn_i      (in_mn),
        .rs_i      (in_rs),
        .rt_i      (in_rt),
        .rd_i      (in_rd),
        .shamt_i   (in_shamt),
        .imm_i     (in_imm),
        .target_i  (in_target),
        .word_o    (word),
        .illegal_o (illegal)
    );

    assign accept = in_valid & in_ready;
    assign wr_ok  = accept & ~illegal;
    assign bad_mn = accept & illegal;
    assign last   = (count_q + 1'b1) == DEPTH_C;

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start always reopens a session
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bad_mn) begin
                        state_d = ST_ERROR;
                    end else if (wr_ok && last) begin
                        state_d = ST_FULL;
                    end
                end
                ST_IDLE, ST_FULL, ST_ERROR: state_d = state_q;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake output: accept only while running and not restarting
    always_comb begin
        in_ready = (state_q == ST_RUN) & ~start;
    end

    // Counter, sticky error and write-port next values
    always_comb begin
        count_d     = count_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (start) begin
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            if (wr_ok) begin
                count_d = count_q + 1'b1;
            end
            if (bad_mn) begin
                err_d = 1'b1;
            end
        end
        if (wr_ok) begin
            mem_addr_d  = BASE_ADDR + (32'(count_q) << 2);
            mem_wdata_d = word;
        end
    end

    // Datapath registers; reset drops any in-flight strobe
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q     <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            count_q     <= count_d;
            err_q       <= err_d;
            mem_we_q    <= wr_ok;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: table-driven reference encoder,
// directed loader scenarios and randomized instruction streams.
module tb_instr_encoder;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_mn = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_shamt = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [$clog2(DEPTH):0] count;
    logic        full;
    logic        err;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mn     (in_mn),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .in_target (in_target),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .full      (full),
        .err       (err)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc = cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [5:0]  mn;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
    } ins_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];

    // Reference table: opcode, funct, format kind, which fields survive
    bit t_ok[64];
    int t_op[64];
    int t_fn[64];
    int t_kind[64];
    bit t_rs[64], t_rt[64], t_rd[64], t_sh[64];
    int t_rtf[64];

    task automatic add(int mn, int kind, int op, int fn,
                       bit rs, bit rt, bit rd, bit sh, int rtf);
        t_ok[mn] = 1; t_kind[mn] = kind; t_op[mn] = op; t_fn[mn] = fn;
        t_rs[mn] = rs; t_rt[mn] = rt; t_rd[mn] = rd; t_sh[mn] = sh;
        t_rtf[mn] = rtf;
    endtask

    task automatic init_table();
        int rfn[12] = '{'h20, 'h21, 'h22, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 'h00, 'h02, 'h08};
        int iop[14] = '{'h08, 'h09, 'h0C, 'h0D, 'h0E, 'h0A, 'h0B, 'h0F,
                        'h23, 'h20, 'h21, 'h2B, 'h28, 'h29};
        for (int i = 0; i < 64; i++) t_ok[i] = 0;
        for (int i = 0; i < 9; i++) add(i, 0, 0, rfn[i], 1, 1, 1, 0, -1);
        add(9, 0, 0, rfn[9], 0, 1, 1, 1, -1);
        add(10, 0, 0, rfn[10], 0, 1, 1, 1, -1);
        add(11, 0, 0, rfn[11], 1, 0, 0, 0, -1);
        for (int i = 0; i < 14; i++) add(16 + i, 1, iop[i], 0, (i != 7), 1, 0, 0, -1);
        add(32, 1, 'h04, 0, 1, 1, 0, 0, -1);
        add(33, 1, 'h05, 0, 1, 1, 0, 0, -1);
        add(34, 1, 'h06, 0, 1, 0, 0, 0, -1);
        add(35, 1, 'h07, 0, 1, 0, 0, 0, -1);
        add(36, 1, 'h01, 0, 1, 0, 0, 0, 0);
        add(37, 1, 'h01, 0, 1, 0, 0, 0, 1);
        add(40, 2, 'h02, 0, 0, 0, 0, 0, -1);
        add(41, 2, 'h03, 0, 0, 0, 0, 0, -1);
`ifdef ENC_SPECIAL2_EN
        add(48, 0, 'h1C, 'h00, 1, 1, 0, 0, -1);
        add(49, 0, 'h1C, 'h04, 1, 1, 0, 0, -1);
        add(50, 0, 'h1C, 'h02, 1, 1, 1, 0, -1);
`endif
    endtask

    function automatic bit ref_enc(input ins_t i, output logic [31:0] w);
        int m = int'(i.mn);
        longint v;
        int rtv;
        w = 0;
        if (!t_ok[m]) return 0;
        rtv = (t_rtf[m] >= 0) ? t_rtf[m] : (t_rt[m] ? int'(i.rt) : 0);
        v = longint'(t_op[m]) * 64'd67108864;
        if (t_kind[m] == 2) begin
            v += longint'(i.tgt);
        end else begin
            v += (t_rs[m] ? longint'(i.rs) : 0) * 64'd2097152;
            v += longint'(rtv) * 64'd65536;
            if (t_kind[m] == 1) begin
                v += longint'(i.imm);
            end else begin
                v += (t_rd[m] ? longint'(i.rd) : 0) * 64'd2048;
                v += (t_sh[m] ? longint'(i.sh) : 0) * 64'd64;
                v += longint'(t_fn[m]);
            end
        end
        w = v[31:0];
        return 1;
    endfunction

    // Model session state
    bit m_open = 0;
    int mcount = 0;
    bit merr = 0;

    function automatic ins_t mk(int mn, int rs, int rt, int rd, int sh, int imm, int tgt);
        ins_t i;
        i.mn = 6'(mn); i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
        i.sh = 5'(sh); i.imm = 16'(imm); i.tgt = 26'(tgt);
        return i;
    endfunction

    task automatic drive(input bit st, input bit v, input ins_t ins,
                         input bit lit_en, input logic [31:0] lit);
        logic [31:0] w;
        bit ok;
        start = st; in_valid = v;
        in_mn = ins.mn; in_rs = ins.rs; in_rt = ins.rt; in_rd = ins.rd;
        in_shamt = ins.sh; in_imm = ins.imm; in_target = ins.tgt;
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_open & ~st));
        if (st) begin
            m_open = 1; mcount = 0; merr = 0;
        end else if (v && m_open) begin
            ok = ref_enc(ins, w);
            if (ok) begin
                q.push_back('{cyc + 1, BASE + 32'(4 * mcount), lit_en ? lit : w});
                mcount++;
                if (mcount == DEPTH) m_open = 0;
            end else begin
                merr = 1; m_open = 0;
            end
        end
        @(posedge Clk); #1;
        start = 0; in_valid = 0;
        chk("count", 32'(count), 32'(mcount));
        chk("full", 32'(full), 32'(mcount == DEPTH));
        chk("err", 32'(err), 32'(merr));
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge Clk) begin
        exp_t e;
        if (!Rst) begin
            if (mem_we) begin
                if (q.size() == 0) begin
                    chk("spurious_we", 32'(mem_we), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("we_cycle", 32'(cyc), 32'(e.cyc));
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_wdata", mem_wdata, e.data);
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                chk("missing_we", 32'(mem_we), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    int legal_mn[37] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
                         16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29,
                         32, 33, 34, 35, 36, 37, 40, 41, 48, 49, 50};

    initial begin
        ins_t nop;
        ins_t add_i;
        init_table();
        nop = mk(0, 0, 0, 0, 0, 0, 0);
        add_i = mk(0, 1, 2, 3, 0, 0, 0);

        // Reset values
        #2;
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(in_ready), 0);
        @(negedge Clk); Rst = 0;
        @(posedge Clk); #1;

        // Idle ignores input
        drive(0, 1, add_i, 0, 0);
        drive(1, 0, nop, 0, 0);
        drive(0, 1, add_i, 1, 32'h0022_1820);

        // Back-to-back from a fresh session, then fill to DEPTH
        drive(1, 0, nop, 0, 0);
        drive(0, 1, mk(16, 0, 8, 0, 0, 'hFFFF, 0), 1, 32'h2008_FFFF);
        drive(0, 1, mk(24, 29, 9, 0, 0, 4, 0), 1, 32'h8FA9_0004);
        drive(0, 1, mk(40, 0, 0, 0, 0, 0, 'h0100000), 1, 32'h0810_0000);
        drive(0, 1, mk(37, 4, 7, 0, 0, 'hFFFE, 0), 1, 32'h0481_FFFE);
        drive(0, 1, add_i, 0, 0);
        drive(0, 0, nop, 0, 0);

        // Restart writes to base again
        drive(1, 0, nop, 0, 0);
        drive(0, 1, add_i, 0, 0);

        // Special2
        drive(1, 0, nop, 0, 0);
`ifdef ENC_SPECIAL2_EN
        drive(0, 1, mk(48, 4, 5, 9, 0, 0, 0), 1, 32'h7085_0000);
`else
        drive(0, 1, mk(48, 4, 5, 9, 0, 0, 0), 0, 0);
`endif
        drive(0, 1, add_i, 0, 0);
        drive(0, 0, nop, 0, 0);

        // Illegal code, then start with valid together
        drive(1, 0, nop, 0, 0);
        drive(0, 1, mk(63, 1, 1, 1, 1, 1, 1), 0, 0);
        drive(0, 1, add_i, 0, 0);
        drive(1, 1, add_i, 0, 0);
        drive(0, 0, nop, 0, 0);

        // Reset during a streaming burst
        drive(0, 1, add_i, 0, 0);
        drive(0, 1, mk(4, 7, 8, 9, 3, 0, 0), 0, 0);
        Rst = 1;
        #1;
        chk("rrst_we", 32'(mem_we), 0);
        chk("rrst_addr", mem_addr, 0);
        chk("rrst_wdata", mem_wdata, 0);
        chk("rrst_count", 32'(count), 0);
        chk("rrst_full", 32'(full), 0);
        chk("rrst_err", 32'(err), 0);
        chk("rrst_ready", 32'(in_ready), 0);
        q.delete();
        m_open = 0; mcount = 0; merr = 0;
        @(negedge Clk); #1; Rst = 0;
        @(posedge Clk); #1;

        // Randomized streams
        for (int n = 0; n < 400; n++) begin
            ins_t r;
            bit st;
            bit v;
            int mn;
            st = m_open ? ($urandom_range(24) == 0) : ($urandom_range(2) == 0);
            v = $urandom_range(9) < 7;
            if ($urandom_range(9) < 8) mn = legal_mn[$urandom_range(36)];
            else mn = int'($urandom_range(63));
            r = mk(mn, int'($urandom), int'($urandom), int'($urandom),
                   int'($urandom), int'($urandom), int'($urandom));
            drive(st, v, r, 0, 0);
        end

        repeat (2) @(posedge Clk);
        #1;
        chk("queue_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
